// File: rtl/meter_credit_ctrl_if.sv
// Coin-meter credit controller bus.
// Strobes and presets in; count, BCD and status out.
interface meter_credit_ctrl_if;
  logic        tick;
  logic [3:0]  req;
  logic        preset10;
  logic        preset205;
  logic [13:0] count;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [3:0]  grant;
  logic        flash;
  logic        expired;
  logic        overrun;
  logic        busy;

  modport master (
    output tick, req, preset10, preset205,
    input  count, bcd, bcd_valid, grant,
    input  flash, expired, overrun, busy
  );

  modport slave (
    input  tick, req, preset10, preset205,
    output count, bcd, bcd_valid, grant,
    output flash, expired, overrun, busy
  );
endinterface

// File: rtl/meter_credit_ctrl.sv
// Parking-meter credit counter with pending-strobe arbitration
// and a 14-cycle double-dabble binary-to-BCD converter.
module meter_credit_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  meter_credit_ctrl_if.slave bus
);
  typedef enum logic {IDLE, CONV} state_t;

  state_t      state;
  logic [13:0] count;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [3:0]  grant;
  logic        overrun;
  logic [3:0]  pend_coin;
  logic        pend_tick;
  logic [13:0] conv_bin;
  logic [14:0] conv_bcd;
  logic [3:0]  step;

  logic [3:0]  low;
  logic [9:0]  add_val;
  logic [14:0] sum;
  logic [3:0]  pc_nxt;
  logic        pt_nxt;
  logic [13:0] cnt_nxt;
  logic [3:0]  gnt_nxt;
  logic        upd;
  logic [14:0] dab;
  logic [15:0] sh_bcd;

  // Thousands digit never exceeds 4 before a shift (count <= 9999),
  // so only the lower three digits need the add-3 correction.
  function automatic logic [14:0] dabble(
    input logic [14:0] v
  );
    logic [14:0] r;
    r = v;
    for (int i = 0; i < 3; i++)
      if (r[i*4 +: 4] > 4'd4)
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  always_comb begin
    low = pend_coin & (~pend_coin + 4'd1);
    add_val = '0;
    unique case (1'b1)
      low[0]:  add_val = 10'd10;
      low[1]:  add_val = 10'd180;
      low[2]:  add_val = 10'd200;
      low[3]:  add_val = 10'd550;
      default: add_val = '0;
    endcase
    sum = {1'b0, count} + {5'b0, add_val};

    pc_nxt  = pend_coin | bus.req;
    pt_nxt  = pend_tick | bus.tick;
    cnt_nxt = count;
    gnt_nxt = '0;
    upd     = 1'b0;
    if (state == IDLE) begin
      if (bus.preset205 | bus.preset10) begin
        upd     = 1'b1;
        cnt_nxt = bus.preset205 ? 14'd205 : 14'd10;
        pc_nxt  = '0;
        pt_nxt  = 1'b0;
      end else if (pend_tick) begin
        upd     = 1'b1;
        pt_nxt  = 1'b0;
        cnt_nxt = (count != 14'd0) ? count - 14'd1 : count;
      end else if (|pend_coin) begin
        upd     = 1'b1;
        pc_nxt  = (pend_coin | bus.req) & ~low;
        gnt_nxt = low;
        cnt_nxt = (sum > 15'd9999) ? 14'd9999 : sum[13:0];
      end
    end

    dab    = dabble(conv_bcd);
    sh_bcd = {dab, conv_bin[13]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
      grant     <= '0;
      overrun   <= 1'b0;
      pend_coin <= '0;
      pend_tick <= 1'b0;
      conv_bin  <= '0;
      conv_bcd  <= '0;
      step      <= '0;
    end else begin
      pend_coin <= pc_nxt;
      pend_tick <= pt_nxt;
      grant     <= gnt_nxt;
      overrun   <= (|(bus.req & pend_coin))
                 | (bus.tick & pend_tick);
      unique case (state)
        IDLE: begin
          if (upd) begin
            count     <= cnt_nxt;
            bcd_valid <= 1'b0;
            conv_bin  <= cnt_nxt;
            conv_bcd  <= '0;
            step      <= '0;
            state     <= CONV;
          end
        end
        CONV: begin
          conv_bcd <= sh_bcd[14:0];
          conv_bin <= {conv_bin[12:0], 1'b0};
          step     <= step + 4'd1;
          if (step == 4'd13) begin
            bcd       <= sh_bcd;
            bcd_valid <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.count     = count;
  assign bus.bcd       = bcd;
  assign bus.bcd_valid = bcd_valid;
  assign bus.grant     = grant;
  assign bus.overrun   = overrun;
  assign bus.busy      = (state == CONV);
  assign bus.flash     = (count < 14'd200);
  assign bus.expired   = (count == 14'd0);
endmodule

// File: tb/tb_meter_credit_ctrl.sv
// Scoreboard bench for meter_credit_ctrl: expected updates are
// queued at stimulus time and checked as the DUT completes them.
module tb_meter_credit_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  meter_credit_ctrl_if bus();

  meter_credit_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  g;
    logic [13:0] c;
  } exp_t;

  exp_t        q_upd[$];
  logic [13:0] q_bcd[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ov_cnt = 0;
  int          m_cnt = 0;
  int          clen = 0;
  bit          mon_en = 0;
  logic        prev_v = 1'b1;

  function automatic logic [15:0] to_bcd(input logic [13:0] c);
    int v;
    v = int'(c);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 9999) ? 9999 : a + b;
  endfunction

  task automatic expect_upd(input logic [3:0] g, input int c);
    exp_t e;
    e.g = g;
    e.c = 14'(c);
    q_upd.push_back(e);
    m_cnt = c;
  endtask

  task automatic monitor();
    exp_t e;
    logic [13:0] ec;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_v = 1'b1;
        clen = 0;
      end else begin
        if (bus.overrun) ov_cnt++;
        n_checks++;
        if (prev_v && !bus.bcd_valid) begin
          clen = 0;
          if (q_upd.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_update count=%0d grant=%b",
                     bus.count, bus.grant);
          end else begin
            e = q_upd.pop_front();
            q_bcd.push_back(e.c);
            if (bus.grant !== e.g || bus.count !== e.c) begin
              n_fail++;
              $display("FAIL update got g=%b c=%0d exp g=%b c=%0d",
                       bus.grant, bus.count, e.g, e.c);
            end
          end
        end else if (bus.grant !== 4'd0) begin
          n_fail++;
          $display("FAIL stray_grant got=%b exp=0000", bus.grant);
        end
        if (!bus.bcd_valid) clen++;
        if (!prev_v && bus.bcd_valid) begin
          n_checks++;
          if (q_bcd.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_bcd got=%h", bus.bcd);
          end else begin
            ec = q_bcd.pop_front();
            if (bus.bcd !== to_bcd(ec) || clen != 14) begin
              n_fail++;
              $display("FAIL bcd got=%h/%0dcyc exp=%h/14cyc",
                       bus.bcd, clen, to_bcd(ec));
            end
          end
        end
        prev_v = bus.bcd_valid;
      end
    end
  endtask

  task automatic pulse(input logic [3:0] r, input logic t);
    @(negedge clk); #1;
    bus.req = r;
    bus.tick = t;
    @(negedge clk); #1;
    bus.req = '0;
    bus.tick = 1'b0;
  endtask

  task automatic preset(input logic p10, input logic p205,
                        input logic [3:0] r);
    @(negedge clk); #1;
    bus.preset10 = p10;
    bus.preset205 = p205;
    bus.req = r;
    @(negedge clk); #1;
    bus.preset10 = 1'b0;
    bus.preset205 = 1'b0;
    bus.req = '0;
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (q_upd.size() == 0 && q_bcd.size() == 0 &&
          bus.bcd_valid && !bus.busy)
        done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout pending=%0d", tag, q_upd.size());
      q_upd.delete();
      q_bcd.delete();
    end
  endtask

  task automatic wait_busy(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk); #1;
      if (bus.busy) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_busy_timeout busy=%b exp=1", tag, bus.busy);
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    q_upd.delete();
    q_bcd.delete();
    m_cnt = 0;
    #1 rst_n = 1'b1;
    mon_en = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.count !== 14'd0 || bus.bcd !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_val got c=%0d b=%h exp 0/0000",
               bus.count, bus.bcd);
    end
    n_checks++;
    if ({bus.bcd_valid, bus.grant, bus.overrun, bus.busy}
        !== 7'b1_0000_0_0) begin
      n_fail++;
      $display("FAIL reset_ctl got v=%b g=%b o=%b b=%b exp 1/0/0/0",
               bus.bcd_valid, bus.grant, bus.overrun, bus.busy);
    end
    n_checks++;
    if (bus.flash !== 1'b1 || bus.expired !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags got f=%b e=%b exp 1/1",
               bus.flash, bus.expired);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.count !== 14'd0 || bus.bcd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_quiet got c=%0d v=%b exp 0/1",
               bus.count, bus.bcd_valid);
    end
  endtask

  task automatic test_single_coin();
    expect_upd(4'b1000, 550);
    pulse(4'b1000, 1'b0);
    wait_drain("single");
    n_checks++;
    if (bus.count !== 14'd550 || bus.bcd !== 16'h0550) begin
      n_fail++;
      $display("FAIL single_val got c=%0d b=%h exp 550/0550",
               bus.count, bus.bcd);
    end
    n_checks++;
    if (bus.flash !== 1'b0 || bus.expired !== 1'b0) begin
      n_fail++;
      $display("FAIL single_flags got f=%b e=%b exp 0/0",
               bus.flash, bus.expired);
    end
  endtask

  task automatic test_all_coins();
    do_reset();
    expect_upd(4'b0001, 10);
    expect_upd(4'b0010, 190);
    expect_upd(4'b0100, 390);
    expect_upd(4'b1000, 940);
    pulse(4'b1111, 1'b0);
    wait_drain("all");
    n_checks++;
    if (bus.count !== 14'd940 || bus.bcd !== 16'h0940) begin
      n_fail++;
      $display("FAIL all_val got c=%0d b=%h exp 940/0940",
               bus.count, bus.bcd);
    end
  endtask

  task automatic test_priority();
    do_reset();
    expect_upd(4'b0000, 0);
    expect_upd(4'b0001, 10);
    pulse(4'b0001, 1'b1);
    wait_drain("prio");
    n_checks++;
    if (bus.count !== 14'd10) begin
      n_fail++;
      $display("FAIL prio_val got=%0d exp=10", bus.count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      expect_upd(4'b1000, sat_add(m_cnt, 550));
      pulse(4'b1000, 1'b0);
      wait_drain("fill");
    end
    n_checks++;
    if (bus.count !== 14'd9900 || bus.bcd !== 16'h9900) begin
      n_fail++;
      $display("FAIL fill_val got c=%0d b=%h exp 9900/9900",
               bus.count, bus.bcd);
    end
    expect_upd(4'b1000, sat_add(m_cnt, 550));
    pulse(4'b1000, 1'b0);
    wait_drain("sat");
    n_checks++;
    if (bus.count !== 14'd9999 || bus.bcd !== 16'h9999) begin
      n_fail++;
      $display("FAIL sat_val got c=%0d b=%h exp 9999/9999",
               bus.count, bus.bcd);
    end
    expect_upd(4'b0001, sat_add(m_cnt, 10));
    pulse(4'b0001, 1'b0);
    wait_drain("sat_again");
    n_checks++;
    if (bus.count !== 14'd9999) begin
      n_fail++;
      $display("FAIL sat_hold got=%0d exp=9999", bus.count);
    end
  endtask

  task automatic test_tick();
    do_reset();
    expect_upd(4'b0000, 10);
    preset(1'b1, 1'b0, 4'b0000);
    wait_drain("p10");
    for (int i = 0; i < 9; i++) begin
      expect_upd(4'b0000, m_cnt - 1);
      pulse(4'b0000, 1'b1);
      wait_drain("tick");
    end
    n_checks++;
    if (bus.count !== 14'd1 || bus.expired !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_one got c=%0d e=%b exp 1/0",
               bus.count, bus.expired);
    end
    expect_upd(4'b0000, 0);
    pulse(4'b0000, 1'b1);
    wait_drain("tick_zero");
    n_checks++;
    if (bus.count !== 14'd0 || bus.expired !== 1'b1 ||
        bus.flash !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_zero got c=%0d e=%b f=%b exp 0/1/1",
               bus.count, bus.expired, bus.flash);
    end
    expect_upd(4'b0000, 0);
    pulse(4'b0000, 1'b1);
    wait_drain("tick_hold");
    n_checks++;
    if (bus.count !== 14'd0 || bus.bcd !== 16'h0) begin
      n_fail++;
      $display("FAIL tick_hold got c=%0d b=%h exp 0/0000",
               bus.count, bus.bcd);
    end
  endtask

  task automatic test_presets();
    expect_upd(4'b0000, 205);
    preset(1'b1, 1'b1, 4'b0010);
    wait_drain("presets");
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.count !== 14'd205 || bus.bcd !== 16'h0205 ||
        bus.flash !== 1'b0) begin
      n_fail++;
      $display("FAIL presets got c=%0d b=%h f=%b exp 205/0205/0",
               bus.count, bus.bcd, bus.flash);
    end
  endtask

  task automatic test_overrun();
    ov_cnt = 0;
    expect_upd(4'b0001, 215);
    pulse(4'b0001, 1'b0);
    wait_busy("ovr");
    expect_upd(4'b0100, 415);
    pulse(4'b0100, 1'b0);
    repeat (2) @(negedge clk);
    pulse(4'b0100, 1'b0);
    n_checks++;
    if (bus.overrun !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_pulse got o=%b b=%b exp 1/1",
               bus.overrun, bus.busy);
    end
    wait_drain("ovr");
    n_checks++;
    if (ov_cnt != 1 || bus.count !== 14'd415) begin
      n_fail++;
      $display("FAIL ovr_result got n=%0d c=%0d exp 1/415",
               ov_cnt, bus.count);
    end
  endtask

  task automatic test_reset_abort();
    expect_upd(4'b0010, 595);
    pulse(4'b0010, 1'b0);
    wait_busy("abort");
    repeat (4) @(negedge clk);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.count, bus.bcd, bus.bcd_valid, bus.grant,
         bus.overrun, bus.busy, bus.flash, bus.expired}
        !== {14'd0, 16'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1})
    begin
      n_fail++;
      $display("FAIL abort got c=%0d b=%h v=%b b=%b exp 0/0000/1/0",
               bus.count, bus.bcd, bus.bcd_valid, bus.busy);
    end
    q_upd.delete();
    q_bcd.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.count !== 14'd0 || bus.bcd !== 16'h0 ||
        bus.bcd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_after got c=%0d b=%h v=%b exp 0/0000/1",
               bus.count, bus.bcd, bus.bcd_valid);
    end
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.req = '0;
    bus.preset10 = 1'b0;
    bus.preset205 = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_coin();
    test_all_coins();
    test_priority();
    test_saturate();
    test_tick();
    test_presets();
    test_overrun();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
